// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the direct-mapped instruction cache.
//   state_e  : controller FSM states (IDLE, FETCH, FILL)
//   widths   : line width, block address width, word offset width
//   word_sel : picks one 32-bit instruction word out of a 128-bit line
package icache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned BLK_ADDR_W = 28;
  localparam int unsigned BLK_OFF_W  = 4;   // byte offset bits within a 16-byte line
  localparam int unsigned WORD_OFF_W = 2;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned WAIT_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_e;

  // Word n of a line lives in bits [32n+31:32n] (little-endian byte order).
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0]     line,
                                                 input logic [WORD_OFF_W-1:0] off);
    logic [WORD_W-1:0] w;
    w = line[0 +: WORD_W];
    case (off)
      2'd1:    w = line[WORD_W +: WORD_W];
      2'd2:    w = line[2*WORD_W +: WORD_W];
      2'd3:    w = line[3*WORD_W +: WORD_W];
      default: w = line[0 +: WORD_W];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays for the direct-mapped cache.
//   clk, rst_n  : clock, async active-low reset (clears valid bits only)
//   wr_en       : write one line (tag + data) and set its valid bit
//   wr_idx/tag/data : write port
//   rd_idx      : combinational lookup index
//   rd_valid_c, rd_tag_c, rd_data_c : combinational read of the indexed line
module icache_line_store
  import icache_pkg::*;
#(
  parameter  int unsigned LINES = 8,
  localparam int unsigned IW    = $clog2(LINES),
  localparam int unsigned TAG_W = ADDR_W - BLK_OFF_W - IW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic              rd_valid_c,
  output logic [TAG_W-1:0]  rd_tag_c,
  output logic [LINE_W-1:0] rd_data_c
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Valid bits: set on fill, cleared only by reset.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data storage needs no reset: contents are qualified by valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid_c = valid_q[rd_idx];
  assign rd_tag_c   = tag_q[rd_idx];
  assign rd_data_c  = data_q[rd_idx];

endmodule

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped instruction cache between the fetch stage and
// a 128-bit block instruction memory. Hits return data in the same cycle; a miss
// reads one 16-byte block (FETCH, at least two cycles), writes it (FILL), then the
// lookup is repeated in IDLE and hits.
//   clock, reset         : clock, async active-low reset
//   read, address        : CPU fetch request and byte address
//   readdata, busywait   : instruction word (combinational) and CPU stall
//   mem_read, mem_address, mem_readdata, mem_busywait : block memory read port
//   hit_count, miss_count: performance counters
// Optional feature macro: ICACHE_PERF_CNT_EN enables the counters; otherwise
// hit_count and miss_count are tied to zero.
module icache_controller
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  output logic [WORD_W-1:0]     readdata,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [BLK_ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0]     mem_readdata,
  input  logic                  mem_busywait,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int unsigned IW    = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - BLK_OFF_W - IW;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic                  mem_read_q, mem_read_d;
  logic [BLK_ADDR_W-1:0] mem_address_q, mem_address_d;

  logic [WORD_OFF_W-1:0] word_off;
  logic [IW-1:0]         req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [IW-1:0]         lat_idx;
  logic [TAG_W-1:0]      lat_tag;
  logic                  rd_valid_c;
  logic [TAG_W-1:0]      rd_tag_c;
  logic [LINE_W-1:0]     rd_data_c;
  logic                  hit_c;
  logic                  miss_c;
  logic                  fill_we_c;
  logic                  unused_addr_lsb;

  // Byte-within-word bits carry no information for 32-bit fetches.
  assign unused_addr_lsb = ^address[WORD_OFF_W-1:0];

  assign word_off = address[BLK_OFF_W-1:WORD_OFF_W];
  assign req_idx  = address[BLK_OFF_W+IW-1:BLK_OFF_W];
  assign req_tag  = address[ADDR_W-1:BLK_OFF_W+IW];

  // The latched block address doubles as the fill index and tag.
  assign lat_idx  = mem_address_q[IW-1:0];
  assign lat_tag  = mem_address_q[BLK_ADDR_W-1:IW];

  icache_line_store #(
    .LINES (LINES)
  ) u_store (
    .clk        (clock),
    .rst_n      (reset),
    .wr_en      (fill_we_c),
    .wr_idx     (lat_idx),
    .wr_tag     (lat_tag),
    .wr_data    (mem_readdata),
    .rd_idx     (req_idx),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c)
  );

  assign hit_c  = rd_valid_c && (rd_tag_c == req_tag);
  assign miss_c = (state_q == IDLE) && read && !hit_c;

  // Stall is combinational so a miss stalls the CPU in the lookup cycle itself.
  assign busywait = (state_q != IDLE) || (read && !hit_c);
  assign readdata = word_sel(rd_data_c, word_off);

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    fill_we_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_c) begin
          state_d       = FETCH;
          cnt_d         = '0;
          mem_read_d    = 1'b1;
          mem_address_d = address[ADDR_W-1:BLK_OFF_W];
        end
      end
      FETCH: begin
        // Minimum two FETCH cycles: the first edge only advances the counter.
        if ((cnt_q != '0) && !mem_busywait) begin
          fill_we_c  = 1'b1;
          state_d    = FILL;
          mem_read_d = 1'b0;
        end else if (cnt_q != WAIT_W'(3)) begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;

`ifdef ICACHE_PERF_CNT_EN
  logic             lookup_hit_c;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  assign lookup_hit_c = (state_q == IDLE) && read && hit_c;

  // Free-running wrap-around counters.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (lookup_hit_c) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end
    if (miss_c) begin
      miss_count_d = miss_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller (LINES=8): each access pushes its
// expected word and stall length; the monitor pops on every presented response.
// Expected block addresses of misses are checked when mem_read rises.
module tb_icache_controller;

`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [31:0]  address;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [27:0] maddr_q[$];
  exp_t        mon_e;
  exp_t        drop_e;
  logic [27:0] mon_a;
  int          total = 0;
  int          bad = 0;
  int          stall_cnt = 0;
  int          stall_left = 0;
  logic        prev_mem_read = 1'b0;
  logic [27:0] prev_maddr = '0;

  icache_controller #(.LINES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] blk(input logic [27:0] a);
    case (a)
      28'h4:   return {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
      28'h8:   return {32'h80000003, 32'h80000002, 32'h80000001, 32'h80000000};
      28'hC:   return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      28'h10:  return {32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000};
      default: return '0;
    endcase
  endfunction

  // Block memory model: busy for stall_left cycles of an active read.
  always @(negedge clock) begin
    mem_readdata = blk(mem_address);
    if (mem_read === 1'b1 && stall_left > 0) begin
      mem_busywait = 1'b1;
      stall_left--;
    end else begin
      mem_busywait = 1'b0;
    end
  end

  // Monitor: responses and memory-side protocol.
  always @(negedge clock) begin
    if (reset === 1'b1 && read === 1'b1) begin
      if (busywait === 1'b1) begin
        stall_cnt++;
      end else begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected addr=%h data=%h", address, readdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (readdata !== mon_e.data || stall_cnt != mon_e.stall)
            begin
              bad++;
              $display("FAIL resp addr=%h got data=%h stall=%0d want data=%h stall=%0d",
                       mon_e.addr, readdata, stall_cnt, mon_e.data, mon_e.stall);
            end
        end
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
    if (mem_read === 1'b1) begin
      total++;
      if (busywait !== 1'b1) begin
        bad++;
        $display("FAIL busy_in_fetch busywait=%b want 1", busywait);
      end
      total++;
      if (!prev_mem_read) begin
        if (maddr_q.size() == 0) begin
          bad++;
          $display("FAIL mem_read_unexpected mem_address=%h want no mem_read", mem_address);
        end else begin
          mon_a = maddr_q.pop_front();
          if (mem_address !== mon_a) begin
            bad++;
            $display("FAIL mem_addr got=%h want=%h", mem_address, mon_a);
          end
        end
      end else if (mem_address !== prev_maddr) begin
        bad++;
        $display("FAIL mem_addr_stable got=%h want=%h", mem_address, prev_maddr);
      end
    end
    prev_mem_read = (mem_read === 1'b1);
    prev_maddr    = mem_address;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic check_perf(input int eh, input int em, input string nm);
    int wh;
    int wm;
    wh = PERF_EN ? eh : 0;
    wm = PERF_EN ? em : 0;
    total++;
    if (hit_count !== 32'(wh) || miss_count !== 32'(wm)) begin
      bad++;
      $display("FAIL perf_%s got hit=%0d miss=%0d want hit=%0d miss=%0d",
               nm, hit_count, miss_count, wh, wm);
    end
  endtask

  // One fetch held until served; st=0 means hit, otherwise a miss is expected.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input int st);
    bit done;
    @(posedge clock); #1;
    exp_q.push_back('{a, d, st});
    if (st != 0) maddr_q.push_back(a[31:4]);
    read    = 1'b1;
    address = a;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (busywait === 1'b0) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL access_timeout addr=%h busywait=%b want 0 within 40 cycles", a, busywait);
      if (exp_q.size() > 0) drop_e = exp_q.pop_back();
    end
    @(posedge clock); #1;
    read = 1'b0;
  endtask

  initial begin
    read         = 1'b0;
    address      = '0;
    mem_busywait = 1'b0;
    mem_readdata = '0;
    reset        = 1'b1;
    #1 reset     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_read_held", 32'(mem_read), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_busywait", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    check_perf(0, 0, "reset");

    // Cold miss, then same-line hit.
    access(32'h0000_0040, 32'hAAAAAAAA, 4);
    check_perf(1, 1, "t1");
    access(32'h0000_004C, 32'hDDDDDDDD, 0);
    check_perf(2, 1, "t2");

    // Conflict on index 4.
    access(32'h0000_00C0, 32'h11111111, 4);
    access(32'h0000_00C8, 32'h33333333, 0);
    access(32'h0000_0040, 32'hAAAAAAAA, 4);
    check_perf(5, 3, "t3");

    // Memory busy for 10 FETCH cycles.
    stall_left = 10;
    access(32'h0000_00C4, 32'h22222222, 13);
    check_perf(6, 4, "t4");

    // Reset in the second FETCH cycle.
    @(posedge clock); #1;
    maddr_q.push_back(28'h8);
    read    = 1'b1;
    address = 32'h0000_0080;
    @(posedge clock);
    @(posedge clock); #1;
    chk("t5_mem_read_before", 32'(mem_read), 32'd1);
    reset = 1'b0;
    read  = 1'b0;
    #1;
    chk("t5_mem_read_async", 32'(mem_read), 32'd0);
    chk("t5_mem_address", 32'(mem_address), 32'd0);
    chk("t5_busywait", 32'(busywait), 32'd0);
    check_perf(0, 0, "t5_reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    access(32'h0000_0080, 32'h80000000, 4);
    check_perf(1, 1, "t5a");
    access(32'h0000_0040, 32'hAAAAAAAA, 4);
    check_perf(2, 2, "t5b");

    // read dropped during a miss: fill still completes.
    @(posedge clock); #1;
    maddr_q.push_back(28'h10);
    read    = 1'b1;
    address = 32'h0000_0108;
    @(posedge clock); #1;
    read = 1'b0;
    repeat (5) @(posedge clock);
    access(32'h0000_0108, 32'h10000002, 0);
    check_perf(3, 3, "t6a");
    access(32'h0000_0084, 32'h80000001, 4);
    check_perf(4, 4, "t6b");

    repeat (2) @(posedge clock);
    #1;
    total++;
    if (exp_q.size() != 0 || maddr_q.size() != 0) begin
      bad++;
      $display("FAIL leftover resp=%0d mem=%0d want 0 and 0", exp_q.size(), maddr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_controller.md
# icache_controller

Direct-mapped instruction cache sitting between the CPU fetch stage and the 128-bit block instruction memory. Serves 32-bit instruction reads on hit with zero added latency. On miss, acts as the read initiator on the block-memory interface (read / 28-bit block address / 128-bit readdata / busywait), fills one 16-byte line, then completes the CPU fetch.

## Interface
- LINES, 8: number of cache lines; power of two, 2..64; index width IW = log2(LINES).
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
- read  in  1  CPU fetch request.
- address  in  32  CPU byte address; bits [1:0] ignored; held stable while busywait is high.
- readdata  out  32  instruction word; valid when read=1 and busywait=0.
- busywait  out  1  CPU stall.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  28  block address = latched address[31:4].
- mem_readdata  in  128  block data; byte n of the block occupies bits [8n+7:8n].
- mem_busywait  in  1  memory busy.
- hit_count  out  32  hit counter; valid only with ICACHE_PERF_CNT_EN.
- miss_count  out  32  miss counter; valid only with ICACHE_PERF_CNT_EN.

## Operation
- Address fields:
  - word offset = address[3:2]
  - index = address[3+IW:4]
  - tag = address[31:4+IW]
- Storage per line: valid bit, tag, 128-bit data.
- Hit means valid[index] is set and stored tag equals the address tag.
- readdata = data[index][32*offset+31 : 32*offset]; combinational from the array.
- FSM states: IDLE, FETCH, FILL.
  - IDLE:
    - read=1 and hit: busywait=0.
    - read=1 and miss: busywait=1 combinationally in the same cycle; latch index and tag; go to FETCH.
    - read=0: busywait=0; no state change.
  - FETCH:
    - mem_read=1; mem_address is stable for the whole state.
    - Stays at least 2 cycles; a 2-bit saturating counter is cleared on entry.
    - On the first rising edge where counter≥1 and mem_busywait=0: capture mem_readdata into the latched line, write the tag, set valid, go to FILL.
    - mem_busywait=1 extends FETCH indefinitely.
  - FILL:
    - mem_read=0; busywait=1; go to IDLE next edge.
    - In IDLE the lookup re-evaluates; it now hits.
- busywait = 1 in FETCH and FILL regardless of read.
- No writes from the CPU side; no replacement choice, since the latched index is always overwritten.

## Timing
- Reset values: state=IDLE, all valid=0, mem_read=0, busywait=0 (when read=0), mem_address=0, counters=0. readdata is don't-care until the first fill.
- Hit latency: 0 cycles (same-cycle data).
- Miss penalty: 1 cycle to enter FETCH, plus FETCH cycles (≥2), plus 1 FILL cycle. Minimum is 4 cycles with busywait high.
- mem_read rises on the edge entering FETCH and falls on the edge leaving it; never high outside FETCH.
- CPU address change while busywait=1 is illegal. The fill uses only the latched index and tag.
- Reset during FETCH or FILL:
  - mem_read drops asynchronously; the line is not written; all valid bits are cleared.
  - A memory response arriving after reset release is ignored.
- read deasserted during a miss: the fill still completes. busywait stays high through FILL.

## Configuration
- ICACHE_PERF_CNT_EN defined:
  - hit_count increments on each IDLE cycle with read=1 and hit.
  - miss_count increments on each IDLE→FETCH transition.
  - Both wrap at 2^32 and reset to 0.
- Undefined: counters are not instantiated; hit_count and miss_count are tied to 0.

## Structure
- Package icache_pkg: state enum (IDLE, FETCH, FILL); constants for line width 128, block address width 28, word offset width 2.
- Sub-module icache_line_store: valid/tag/data arrays with asynchronous clear of valid, a single write port, and a combinational read by index.

## Test plan
1. After reset, read=1, address=0x00000040 → busywait=1, mem_read=1, mem_address=0x0000004. Memory returns block 0x…DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → readdata=0xAAAAAAAA, busywait=0 in the first IDLE cycle after FILL; miss_count=1.
2. Then address=0x4C (same line, offset 3) → busywait=0 in the same cycle, readdata=0xDDDDDDDD, no mem_read; hit_count increments.
3. Conflict with LINES=8: address=0x0000_00C0 (same index 4, tag 1) → miss; line refilled. Re-reading 0x40 misses again.
4. mem_busywait held high for 10 cycles in FETCH → mem_read and mem_address stable throughout; busywait stays 1; capture occurs on the first edge with mem_busywait low.
5. Reset pulsed low in the 2nd FETCH cycle → mem_read=0 immediately. After release, a read of the same address misses again.
6. Without ICACHE_PERF_CNT_EN, run scenarios 1–2 → hit_count=0, miss_count=0 throughout.
